// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serial configuration receiver. While program_mode is high it
// shifts one bit per clock from jtag_data_in, assembles MSB-first words and
// writes them to sequential configuration-store addresses. The address wraps
// after each full pass. The serial stream is forwarded on jtag_data_out.
module cfg_chain_loader #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              program_mode,
  input  logic              jtag_data_in,
  output logic              jtag_data_out,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [WORD_W-1:0] cfg_wdata,
  output logic              cfg_done,
  output logic              cfg_valid,
  output logic              cfg_error
);

  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic {
    IDLE,
    LOAD
  } state_e;

  state_e state_q, state_d;

  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  // Only the first WORD_W-1 bits of a word need storing; the last bit goes
  // straight from jtag_data_in into cfg_wdata.
  logic [WORD_W-2:0] sr_q, sr_d;
  logic              pass_complete_q, pass_complete_d;
  logic              dout_q, dout_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;

  // Counter/shift values the current bit builds on: a fresh load starts from zero.
  logic [BC_W-1:0]   bc_base;
  logic [ADDR_W-1:0] wc_base;
  logic [WORD_W-2:0] sr_base;
  logic              pc_base;
  logic [WORD_W-1:0] word_in;
  logic              clean_end;

  // Next-state logic: bit assembly, word write, pass wrap and end-of-load judgement.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    word_cnt_d      = word_cnt_q;
    sr_d            = sr_q;
    pass_complete_d = pass_complete_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    valid_d         = valid_q;
    error_d         = error_q;
    we_d            = 1'b0;
    done_d          = 1'b0;
    dout_d          = program_mode & jtag_data_in;
    bc_base         = bit_cnt_q;
    wc_base         = word_cnt_q;
    sr_base         = sr_q;
    pc_base         = pass_complete_q;
    word_in         = '0;
    clean_end       = 1'b0;

    if (program_mode) begin
      state_d = LOAD;
      if (state_q == IDLE) begin
        // Entering a load: first bit of word 0, flags cleared.
        bc_base = '0;
        wc_base = '0;
        sr_base = '0;
        pc_base = 1'b0;
        valid_d = 1'b0;
        error_d = 1'b0;
      end

      word_in         = {sr_base, jtag_data_in};
      sr_d            = word_in[WORD_W-2:0];
      pass_complete_d = pc_base;
      word_cnt_d      = wc_base;

      if (bc_base == BC_W'(WORD_W - 1)) begin
        we_d      = 1'b1;
        addr_d    = wc_base;
        wdata_d   = word_in;
        bit_cnt_d = '0;
        if (wc_base == ADDR_W'(NUM_WORDS - 1)) begin
          word_cnt_d      = '0;
          pass_complete_d = 1'b1;
          done_d          = 1'b1;
        end else begin
          word_cnt_d = wc_base + ADDR_W'(1);
        end
      end else begin
        bit_cnt_d = bc_base + BC_W'(1);
      end
    end else if (state_q == LOAD) begin
      // Load ended: valid only on an exact pass boundary, partial word dropped.
      state_d   = IDLE;
      clean_end = pass_complete_q && (bit_cnt_q == '0) && (word_cnt_q == '0);
      valid_d   = clean_end;
      error_d   = !clean_end;
      sr_d      = '0;
    end
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      word_cnt_q      <= '0;
      sr_q            <= '0;
      pass_complete_q <= 1'b0;
      dout_q          <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      done_q          <= 1'b0;
      valid_q         <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      word_cnt_q      <= word_cnt_d;
      sr_q            <= sr_d;
      pass_complete_q <= pass_complete_d;
      dout_q          <= dout_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      done_q          <= done_d;
      valid_q         <= valid_d;
      error_q         <= error_d;
    end
  end

  assign jtag_data_out = dout_q;
  assign cfg_we        = we_q;
  assign cfg_addr      = addr_q;
  assign cfg_wdata     = wdata_q;
  assign cfg_done      = done_q;
  assign cfg_valid     = valid_q;
  assign cfg_error     = error_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Testbench for cfg_chain_loader: randomized and directed serial sessions, an
// expected-write queue filled from each session's bit list, and a monitor that
// pops and compares every cfg_we it observes.
module tb_cfg_chain_loader;

  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 256;
  localparam int ADDR_W    = 8;
  localparam int PASS_BITS = WORD_W * NUM_WORDS;

  logic              clk;
  logic              rst;
  logic              program_mode;
  logic              jtag_data_in;
  logic              jtag_data_out;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [WORD_W-1:0] cfg_wdata;
  logic              cfg_done;
  logic              cfg_valid;
  logic              cfg_error;

  cfg_chain_loader #(
    .WORD_W   (WORD_W),
    .NUM_WORDS(NUM_WORDS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .program_mode (program_mode),
    .jtag_data_in (jtag_data_in),
    .jtag_data_out(jtag_data_out),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_done     (cfg_done),
    .cfg_valid    (cfg_valid),
    .cfg_error    (cfg_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic              done;
  } wr_t;

  wr_t exp_q[$];
  bit  bits[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int sess_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pass-through bit: what the coming edge samples.
  logic exp_dout = 1'b0;
  always @(posedge clk) begin
    cyc++;
    exp_dout = rst ? 1'b0 : (program_mode & jtag_data_in);
  end

  // Monitor: compares each observed write against the scoreboard queue.
  int  last_cyc  = 0;
  int  last_sess = -1;
  always @(negedge clk) begin
    wr_t e;
    check("dout_passthru", jtag_data_out, rst ? 1'b0 : exp_dout);
    if (!rst) begin
      if (cfg_done) check("done_implies_we", cfg_we, 1);
      if (cfg_we) begin
        if (exp_q.size() == 0) begin
          check("write_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", cfg_addr, e.addr);
          check("wr_data", cfg_wdata, e.data);
          check("wr_done", cfg_done, e.done);
        end
        if (last_sess == sess_id) check("write_spacing", cyc - last_cyc, WORD_W);
        last_sess = sess_id;
        last_cyc  = cyc;
      end
    end
  end

  task automatic add_word(input logic [WORD_W-1:0] w);
    for (int b = WORD_W - 1; b >= 0; b--) bits.push_back(w[b]);
  endtask

  task automatic add_pass(input bit beef);
    for (int k = 0; k < NUM_WORDS; k++)
      add_word((beef && k == 0) ? 16'hBEEF : 16'(k * 16'h0101));
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) bits.push_back(1'($urandom));
  endtask

  // Drive the bit list as one program_mode session. Reference: every complete
  // group of WORD_W bits is one write to address (index mod NUM_WORDS); the load
  // is valid exactly when the length is a whole number of passes.
  task automatic run_session(input bit chk_dout, input bit chk_end);
    int n;
    bit clean;
    n = bits.size();
    for (int w = 0; w < n / WORD_W; w++) begin
      wr_t e;
      logic [WORD_W-1:0] d;
      d = '0;
      for (int b = 0; b < WORD_W; b++) d = {d[WORD_W-2:0], bits[w*WORD_W + b]};
      e.addr = ADDR_W'(w % NUM_WORDS);
      e.data = d;
      e.done = ((w % NUM_WORDS) == NUM_WORDS - 1);
      exp_q.push_back(e);
    end
    sess_id++;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (chk_dout && i > 0) check("dout_stream", jtag_data_out, bits[i-1]);
      if (i > 0) check("valid_low_in_load", cfg_valid, 0);
      program_mode = 1'b1;
      jtag_data_in = bits[i];
    end
    if (chk_end) begin
      clean = (n > 0) && (n % PASS_BITS == 0);
      @(posedge clk); #1;
      if (chk_dout) check("dout_stream", jtag_data_out, bits[n-1]);
      program_mode = 1'b0;
      jtag_data_in = 1'($urandom);
      @(posedge clk); #1;
      if (chk_dout) check("dout_idle", jtag_data_out, 0);
      check("cfg_valid", cfg_valid, clean);
      check("cfg_error", cfg_error, !clean);
      check("all_writes_seen", exp_q.size(), 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"},  jtag_data_out, 0);
    check({tag, "_we"},    cfg_we, 0);
    check({tag, "_addr"},  cfg_addr, 0);
    check({tag, "_wdata"}, cfg_wdata, 0);
    check({tag, "_done"},  cfg_done, 0);
    check({tag, "_valid"}, cfg_valid, 0);
    check({tag, "_error"}, cfg_error, 0);
  endtask

  initial begin
    rst          = 1'b1;
    program_mode = 1'b1;
    jtag_data_in = 1'b0;

    // Reset held with program_mode high and random serial data.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      jtag_data_in = 1'($urandom);
      check_all_zero("reset");
    end
    @(posedge clk); #1;
    program_mode = 1'b0;
    rst          = 1'b0;
    @(posedge clk); #1;
    check("post_reset_valid", cfg_valid, 0);
    check("post_reset_error", cfg_error, 0);

    // One clean pass of the incrementing pattern.
    bits.delete();
    add_pass(1'b0);
    run_session(1'b0, 1'b1);

    // Four back-to-back copies, word 0 = BEEF in the second copy.
    bits.delete();
    add_pass(1'b0);
    add_pass(1'b1);
    add_pass(1'b0);
    add_pass(1'b0);
    run_session(1'b0, 1'b1);

    // Truncated load: a pass plus 5 bits, then a clean pass.
    bits.delete();
    add_pass(1'b0);
    add_random(5);
    run_session(1'b0, 1'b1);
    bits.delete();
    add_random(PASS_BITS);
    run_session(1'b0, 1'b1);

    // Serial pass-through 1,0,1,1.
    bits.delete();
    bits.push_back(1'b1);
    bits.push_back(1'b0);
    bits.push_back(1'b1);
    bits.push_back(1'b1);
    run_session(1'b1, 1'b1);

    // Random-length sessions separated by random idle gaps.
    for (int s = 0; s < 6; s++) begin
      bits.delete();
      add_random($urandom_range(700, 1));
      run_session(1'b1, 1'b1);
      repeat ($urandom_range(3, 0)) @(posedge clk);
    end

    // Reset in the middle of a load, then a full clean pass.
    bits.delete();
    add_random(2003);
    run_session(1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_all_zero("midload_reset");
    check("midload_writes_seen", exp_q.size(), 0);
    @(posedge clk); #1;
    program_mode = 1'b0;
    rst          = 1'b0;
    @(posedge clk); #1;
    check("after_abort_valid", cfg_valid, 0);
    bits.delete();
    add_pass(1'b1);
    run_session(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
